// File: rtl/rtc_bus_sequencer_if.sv
// Request/response handshake plus RTC strobe and AD-bus signals for the bus sequencer.
interface rtc_bus_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mode_rd;
  logic              cs_n;
  logic              rd_n;
  logic              wr_n;
  logic              ad_n;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              err_timeout;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, cs_n, rd_n, wr_n, ad_n, bus_in,
    output req_ready, mode_rd, bus_out, bus_oe, rdata, done, err_timeout
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, cs_n, rd_n, wr_n, ad_n, bus_in,
    input  req_ready, mode_rd, bus_out, bus_oe, rdata, done, err_timeout
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Drives/samples the RTC multiplexed AD bus in step with the strobe generator's
// CS/RD/WR/AD frames, one single-byte read or write per request.
module rtc_bus_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 96
) (
  input  logic                clk,
  input  logic                reset,
  rtc_bus_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_WAIT_ADDR, S_ADDR, S_WAIT_DATA, S_DATA
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] bin_q;
  logic              mode_q, mode_d;
  logic              cs_q, rd_q;

  logic              ready, oe, done, err;
  logic [DATA_W-1:0] out;
  logic              cs_fall, cs_rise, rd_rise, waiting, timeout;

  assign cs_fall = cs_q & ~bus.cs_n;
  assign cs_rise = ~cs_q & bus.cs_n;
  assign rd_rise = ~rd_q & bus.rd_n;
  assign waiting = (state_q == S_SYNC) || (state_q == S_WAIT_ADDR) || (state_q == S_WAIT_DATA);
  assign timeout = waiting && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mode_q  <= 1'b0;
      bin_q   <= '0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mode_q  <= mode_d;
      bin_q   <= bus.bus_in;
      cs_q    <= bus.cs_n;
      rd_q    <= bus.rd_n;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = waiting ? cnt_q + CNT_W'(1) : cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mode_d  = mode_q;
    ready   = 1'b0;
    oe      = 1'b0;
    out     = '0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          mode_d  = bus.req_rw;
          cnt_d   = '0;
          state_d = S_SYNC;
        end
      end
      // Only a fully quiet bus counts as a frame boundary, so a frame in flight is skipped.
      S_SYNC: begin
        if (timeout) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else if (bus.cs_n && bus.rd_n && bus.wr_n) begin
          state_d = S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        if (cs_fall && !bus.ad_n) begin
          oe      = 1'b1;
          out     = addr_q;
          state_d = S_ADDR;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (!bus.cs_n && !bus.ad_n) begin
          oe  = 1'b1;
          out = addr_q;
        end
        if (cs_rise) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (cs_fall && bus.ad_n) begin
          oe      = ~mode_q;
          out     = mode_q ? '0 : wdata_q;
          state_d = S_DATA;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!mode_q && !bus.cs_n) begin
          oe  = 1'b1;
          out = wdata_q;
        end
        // bin_q still holds the last bus value seen while rd_n was low.
        if (mode_q && rd_rise) rdata_d = bin_q;
        if (cs_rise) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready   = ready & reset;
  assign bus.bus_oe      = oe & reset;
  assign bus.bus_out     = reset ? out : '0;
  assign bus.done        = done & reset;
  assign bus.err_timeout = err & reset;
  assign bus.mode_rd     = mode_q;
  assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench: a 37-cycle generator frame model annotates the expected
// sequencer outputs per cycle; a negedge process compares them every cycle.
module tb_rtc_bus_sequencer;
  localparam int DW = 8;
  localparam int TO = 96;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if #(.DATA_W(DW)) bif();
  rtc_bus_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bif));

  bit          e_ready, e_mode, e_oe, e_done, e_err, chk;
  logic [7:0]  e_out, e_rdata;
  bit          m_rw;
  logic [7:0]  m_addr, m_wd, m_rv;
  int          total = 0, bad = 0, n_done = 0, n_err = 0;

  task automatic cmpv(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmpi(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk) begin
    cmpv("req_ready", {7'd0, bif.req_ready}, {7'd0, e_ready});
    cmpv("mode_rd", {7'd0, bif.mode_rd}, {7'd0, e_mode});
    cmpv("bus_oe", {7'd0, bif.bus_oe}, {7'd0, e_oe});
    if (e_oe || !reset) cmpv("bus_out", bif.bus_out, e_out);
    cmpv("done", {7'd0, bif.done}, {7'd0, e_done});
    cmpv("err_timeout", {7'd0, bif.err_timeout}, {7'd0, e_err});
    cmpv("rdata", bif.rdata, e_rdata);
    if (bif.done === 1'b1) n_done++;
    if (bif.err_timeout === 1'b1) n_err++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bif.cs_n = 1'b1; bif.rd_n = 1'b1; bif.wr_n = 1'b1; bif.ad_n = 1'b1;
    bif.bus_in = 8'h5A;
  endtask

  task automatic exp_clear();
    e_ready = 0; e_oe = 0; e_out = 8'h00; e_done = 0; e_err = 0;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int k = 0; k < n; k++) begin
      bus_idle(); exp_clear(); e_ready = rdy;
      cyc();
    end
  endtask

  // Acceptance cycle on a quiet bus, then the first waiting cycle.
  task automatic request(input bit rw, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] rv, input bit hold);
    bus_idle(); exp_clear(); e_ready = 1;
    bif.req_valid = 1; bif.req_rw = rw; bif.req_addr = a; bif.req_wdata = wd;
    cyc();
    m_rw = rw; m_addr = a; m_wd = wd; m_rv = rv;
    exp_clear(); e_mode = rw; bif.req_valid = hold;
    cyc();
  endtask

  // Frame: addr window i=0..7, gap 8..12, data window 13..32 (strobe 17..28), quiet 33..36.
  // own: this frame carries the pending transaction; acc_at: request accepted at that cycle;
  // hold: req_valid high throughout; rst_at: reset pulsed at that cycle.
  task automatic frame(input bit own, input int acc_at, input bit hold, input int rst_at);
    bit live, idle_st;
    live = own; idle_st = 0;
    for (int i = 0; i < 37; i++) begin
      bus_idle(); exp_clear(); reset = 1;
      bif.req_valid = hold;
      bif.cs_n = !((i < 8) || (i >= 13 && i < 33));
      bif.ad_n = !(i < 8);
      if (i >= 17 && i <= 28) begin
        if (m_rw) bif.rd_n = 0; else bif.wr_n = 0;
      end
      if (!bif.rd_n) bif.bus_in = m_rv;
      if (acc_at >= 0) begin
        if (i <= acc_at) e_ready = 1;
        if (i == acc_at) bif.req_valid = 1;
        if (i == acc_at + 1) e_mode = bif.req_rw;
      end
      if (i == rst_at) begin
        reset = 0; live = 0; idle_st = 1;
      end else if (idle_st) begin
        e_ready = 1;
      end
      if (live) begin
        if (i < 8) begin e_oe = 1; e_out = m_addr; end
        if (!m_rw && i >= 13 && i < 33) begin e_oe = 1; e_out = m_wd; end
        if (i == 33) e_done = 1;
        if (i >= 34) e_ready = !(hold && i >= 35);
        if (hold && i == 35) e_mode = bif.req_rw;
        if (m_rw && i == 30) e_rdata = m_rv;
      end
      cyc();
      if (i == rst_at) begin e_mode = 0; e_rdata = 8'h00; end
    end
  endtask

  initial begin
    bus_idle();
    bif.req_valid = 0; bif.req_rw = 0; bif.req_addr = 8'h00; bif.req_wdata = 8'h00;
    exp_clear(); e_mode = 0; e_rdata = 8'h00;
    m_rw = 0; m_addr = 8'h00; m_wd = 8'h00; m_rv = 8'h00;
    chk = 1;
    reset = 0;
    cyc(); cyc();
    reset = 1;
    idle_cycles(2, 1);

    // 1: write 0x21 <- 0x45
    request(0, 8'h21, 8'h45, 8'h00, 0);
    frame(1, -1, 0, -1);
    cmpi("t1_done_count", n_done, 1);

    // 2: read 0x22, RTC returns 0xA7
    request(1, 8'h22, 8'h00, 8'hA7, 0);
    frame(1, -1, 0, -1);
    cmpv("t2_rdata", bif.rdata, 8'hA7);
    cmpi("t2_done_count", n_done, 2);

    // 3: accepted mid address window; that frame is skipped
    bif.req_rw = 0; bif.req_addr = 8'h30; bif.req_wdata = 8'h6C;
    m_rw = 0; m_addr = 8'h30; m_wd = 8'h6C; m_rv = 8'h00;
    frame(0, 3, 0, -1);
    cmpi("t3_skip_no_done", n_done, 2);
    frame(1, -1, 0, -1);
    cmpi("t3_done_count", n_done, 3);

    // 4: generator stalled; err at acceptance+96
    request(0, 8'h40, 8'h0F, 8'h00, 0);
    idle_cycles(TO - 2, 0);
    bus_idle(); exp_clear(); e_err = 1;
    cyc();
    idle_cycles(2, 1);
    cmpi("t4_err_count", n_err, 1);
    cmpi("t4_no_done", n_done, 3);
    cmpv("t4_rdata_kept", bif.rdata, 8'hA7);

    // 5: reset inside a write data window, then a clean read of 0x23
    request(0, 8'h55, 8'h99, 8'h00, 0);
    frame(1, -1, 0, 20);
    cmpi("t5_dropped", n_done, 3);
    cmpv("t5_rdata_reset", bif.rdata, 8'h00);
    request(1, 8'h23, 8'h00, 8'h3C, 0);
    frame(1, -1, 0, -1);
    cmpv("t5_rdata", bif.rdata, 8'h3C);
    cmpi("t5_done_count", n_done, 4);

    // 6: back-to-back with req_valid held; write then read
    request(0, 8'h61, 8'h17, 8'h00, 1);
    bif.req_rw = 1; bif.req_addr = 8'h62; bif.req_wdata = 8'hEE;
    frame(1, -1, 1, -1);
    cmpv("t6_rdata_after_write", bif.rdata, 8'h3C);
    m_rw = 1; m_addr = 8'h62; m_wd = 8'hEE; m_rv = 8'hD2;
    frame(1, -1, 0, -1);
    cmpv("t6_rdata", bif.rdata, 8'hD2);
    cmpi("t6_done_count", n_done, 6);
    idle_cycles(3, 1);

    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
